// File: rtl/bram_replicate_pkg.sv
// Shared constants and helpers for the replicated, round-robin-written BRAM.
package bram_replicate_pkg;

    localparam int STALL_WIDTH = 32;
    localparam logic [STALL_WIDTH-1:0] STALL_MAX = '1;

    // Only a bare BRAM read (1) or BRAM read plus output register (2) is supported.
    function automatic bit read_latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // Low bit of element idx inside a packed vector of width-bit elements.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bram.sv
// Simple dual-port BRAM: one synchronous write port, one synchronous read-first read port.
module bram #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [LOG2_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**LOG2_DEPTH];

    // Write and registered read; a same-cycle read of the written address returns the old word.
    // NOTE: storage and its read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module rr_arbiter
    import bram_replicate_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    generate
        if (N == 1) begin : g_single
            assign grant = req;
        end else begin : g_rr
            localparam int PTR_W = $clog2(N);

            logic [PTR_W-1:0] ptr;
            logic [PTR_W-1:0] winner;
            logic [PTR_W:0]   cand;
            logic             found;

            // Scan the requesters starting at the pointer; the first hit wins.
            // NOTE: every output of this block gets a default first so no latch is inferred.
            always_comb begin
                grant  = '0;
                winner = ptr;
                found  = 1'b0;
                cand   = '0;
                for (int k = 0; k < N; k++) begin
                    cand = {1'b0, ptr} + (PTR_W + 1)'(k);
                    if (cand >= (PTR_W + 1)'(N)) begin
                        cand = cand - (PTR_W + 1)'(N);
                    end
                    if (!found && req[cand[PTR_W-1:0]]) begin
                        grant[cand[PTR_W-1:0]] = 1'b1;
                        winner                 = cand[PTR_W-1:0];
                        found                  = 1'b1;
                    end
                end
            end

            // Move the pointer just past the channel that was served.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ptr <= '0;
                end else if (accept) begin
                    ptr <= (winner == PTR_W'(N - 1)) ? '0 : winner + PTR_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bram_replicate_rr.sv
// Replicated BRAM: one private copy per read port, all copies written through a
// single round-robin arbitrated write stage shared by every write channel.
module bram_replicate_rr
    import bram_replicate_pkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int LOG2_DEPTH         = 5,
    parameter int NUM_WRITE_CHANNELS = 2,
    parameter int NUM_READ_CHANNELS  = 3,
    parameter int READ_LATENCY       = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_WRITE_CHANNELS-1:0]            wr_we,
    input  logic [NUM_WRITE_CHANNELS*LOG2_DEPTH-1:0] wr_addr,
    input  logic [NUM_WRITE_CHANNELS*WIDTH-1:0]      wr_data,
    output logic [NUM_WRITE_CHANNELS-1:0]            wr_ready,
    input  logic [NUM_READ_CHANNELS-1:0]             rd_re,
    input  logic [NUM_READ_CHANNELS*LOG2_DEPTH-1:0]  rd_addr,
    output logic [NUM_READ_CHANNELS-1:0]             rd_rvalid,
    output logic [NUM_READ_CHANNELS*WIDTH-1:0]       rd_rdata,
    output logic [STALL_WIDTH-1:0]                   stall_count
);

    generate
        if (!read_latency_legal(READ_LATENCY) || NUM_WRITE_CHANNELS < 1 || NUM_READ_CHANNELS < 1) begin : g_param_check
            $error("bram_replicate_rr: illegal parameter set");
        end
    endgenerate

    logic [NUM_WRITE_CHANNELS-1:0] grant;
    logic                          accept;
    logic [LOG2_DEPTH-1:0]         sel_addr;
    logic [WIDTH-1:0]              sel_data;
    logic                          stage_valid;
    logic [LOG2_DEPTH-1:0]         stage_addr;
    logic [WIDTH-1:0]              stage_data;
    logic                          contention;
    logic [STALL_WIDTH-1:0]        stall_q;

    rr_arbiter #(
        .N(NUM_WRITE_CHANNELS)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_we),
        .accept(accept),
        .grant (grant)
    );

    // No grant is visible while reset is held, so nothing can be accepted then.
    assign wr_ready   = grant & {NUM_WRITE_CHANNELS{reset}};
    assign accept     = |(wr_we & wr_ready);
    assign contention = ($countones(wr_we) >= 2);

    // Route the granted channel's address and data into the write stage.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_WRITE_CHANNELS; i++) begin
            if (wr_ready[i]) begin
                sel_addr = wr_addr[slice_lsb(i, LOG2_DEPTH) +: LOG2_DEPTH];
                sel_data = wr_data[slice_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

    // Single write stage; its contents reach every replica one cycle after acceptance.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_data  <= '0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_addr <= sel_addr;
                stage_data <= sel_data;
            end
        end
    end

    // Saturating count of cycles in which two or more writers compete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (contention && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;

    generate
        for (genvar j = 0; j < NUM_READ_CHANNELS; j++) begin : g_port
            logic [WIDTH-1:0] bram_q;

            bram #(
                .WIDTH     (WIDTH),
                .LOG2_DEPTH(LOG2_DEPTH)
            ) u_bram (
                .clk  (clk),
                .we   (stage_valid),
                .waddr(stage_addr),
                .wdata(stage_data),
                .re   (rd_re[j]),
                .raddr(rd_addr[slice_lsb(j, LOG2_DEPTH) +: LOG2_DEPTH]),
                .rdata(bram_q)
            );

            if (READ_LATENCY == 2) begin : g_lat2
                logic             v1;
                logic             v2;
                logic [WIDTH-1:0] q2;

                // Valid pipeline plus output register behind the replica.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        v1 <= 1'b0;
                        v2 <= 1'b0;
                        q2 <= '0;
                    end else begin
                        v1 <= rd_re[j];
                        v2 <= v1;
                        if (v1) begin
                            q2 <= bram_q;
                        end
                    end
                end

                assign rd_rvalid[j]                          = v2;
                assign rd_rdata[slice_lsb(j, WIDTH) +: WIDTH] = q2;
            end else begin : g_lat1
                logic v1;

                // Valid follows the read enable by one cycle, matching the replica read.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        v1 <= 1'b0;
                    end else begin
                        v1 <= rd_re[j];
                    end
                end

                assign rd_rvalid[j]                          = v1;
                assign rd_rdata[slice_lsb(j, WIDTH) +: WIDTH] = bram_q;
            end
        end
    endgenerate

endmodule
